cceip_kernel_example_rd_issuer: RTL and testbench

AXI4 read-address issuer for the CCEIP example kernel datapath. Accepts one transfer command (byte offset, byte length), splits it into fixed-size AR bursts, and limits the number of outstanding bursts with a credit count. The AXI read-data side returns one completion pulse per burst. The block pulses `ctrl_done` when every burst has been issued and completed. It sits between kernel control and the m_axi read channel, upstream of the read-data FIFO.

---
 rtl/cceip_kernel_example_pkg.sv | 15 +
 rtl/cceip_kernel_example_updown_cnt.sv | 39 +++
 rtl/cceip_kernel_example_rd_issuer.sv | 139 +++++++++++++
 tb/tb_cceip_kernel_example_rd_issuer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cceip_kernel_example_pkg.sv
// Shared types and helpers for the CCEIP example kernel datapath.
package cceip_kernel_example_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} rd_issuer_state_t;

  function automatic int unsigned bytes_per_beat(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // AXI4 INCR bursts top out at 256 beats.
  function automatic int unsigned beats_per_burst(input int unsigned burst_len);
    return (burst_len > 256) ? 256 : burst_len;
  endfunction

endpackage

// File: rtl/cceip_kernel_example_updown_cnt.sv
// Load/increment/decrement counter with a registered is-zero flag.
module cceip_kernel_example_updown_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             incr,
  input  logic             decr,
  output logic [Width-1:0] count,
  output logic             is_zero
);

  logic [Width-1:0] count_d;

  // Simultaneous incr/decr cancel; decrement saturates at zero.
  always_comb begin
    count_d = count;
    if (load) begin
      count_d = load_val;
    end else if (incr && !decr) begin
      count_d = count + Width'(1);
    end else if (decr && !incr && (count != '0)) begin
      count_d = count - Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      is_zero <= 1'b1;
    end else begin
      count   <= count_d;
      is_zero <= (count_d == '0);
    end
  end

endmodule

// File: rtl/cceip_kernel_example_rd_issuer.sv
// Splits one read command into fixed-size AXI4 AR bursts under an outstanding-burst credit limit.
module cceip_kernel_example_rd_issuer
  import cceip_kernel_example_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_DATA_WIDTH      = 512,
  parameter int unsigned C_LENGTH_WIDTH    = 32,
  parameter int unsigned C_BURST_LEN       = 64,
  parameter int unsigned C_MAX_OUTSTANDING = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]   ctrl_offset,
  input  logic [C_LENGTH_WIDTH-1:0] ctrl_length,
  output logic                      ctrl_busy,
  output logic                      ctrl_done,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  input  logic                      burst_done
);

  localparam int unsigned LP_BPB   = bytes_per_beat(C_DATA_WIDTH);
  localparam int unsigned LP_BL    = beats_per_burst(C_BURST_LEN);
  localparam int unsigned LP_OUT_W = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int unsigned LP_LW1   = C_LENGTH_WIDTH + 1;

  localparam logic [C_ADDR_WIDTH-1:0] LP_BURST_BYTES = C_ADDR_WIDTH'(LP_BL * LP_BPB);
  localparam logic [LP_LW1-1:0]       LP_BPB_W       = LP_LW1'(LP_BPB);
  localparam logic [LP_LW1-1:0]       LP_BL_W        = LP_LW1'(LP_BL);
  localparam logic [LP_OUT_W-1:0]     LP_MAX_CNT     = LP_OUT_W'(C_MAX_OUTSTANDING);
  localparam logic [7:0]              LP_FULL_ARLEN  = 8'(LP_BL - 1);

  rd_issuer_state_t state_q, state_d;

  logic                      start_ok;
  logic                      ar_hs;
  logic [LP_LW1-1:0]         beats;
  logic [LP_LW1-1:0]         beats_mod;
  logic [C_LENGTH_WIDTH-1:0] bursts;
  logic [7:0]                last_arlen;
  logic [C_ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]                arlen_q;
  logic [7:0]                last_arlen_q;
  logic [LP_OUT_W-1:0]       out_cnt;
  logic                      out_zero;
  logic [C_LENGTH_WIDTH-1:0] rem_cnt;
  logic                      rem_zero;

  // Command decode; the extra length bit keeps the round-up from overflowing.
  always_comb begin
    beats      = ({1'b0, ctrl_length} + LP_BPB_W - LP_LW1'(1)) / LP_BPB_W;
    bursts     = C_LENGTH_WIDTH'((beats + LP_BL_W - LP_LW1'(1)) / LP_BL_W);
    beats_mod  = beats % LP_BL_W;
    last_arlen = (beats_mod == '0) ? LP_FULL_ARLEN : 8'(beats_mod - LP_LW1'(1));
  end

  assign m_axi_arvalid = (state_q == StIssue) && !rem_zero && (out_cnt != LP_MAX_CNT);
  assign ar_hs         = m_axi_arvalid && m_axi_arready;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = arlen_q;
  assign ctrl_busy     = (state_q == StIssue) || (state_q == StDrain);
  assign ctrl_done     = (state_q == StDone);

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctrl_start) begin
          start_ok = 1'b1;
          // Zero length passes through DRAIN (nothing outstanding) so done lands at start+2.
          state_d  = (ctrl_length == '0) ? StDrain : StIssue;
        end
      end
      StIssue: begin
        if (ar_hs && (rem_cnt == C_LENGTH_WIDTH'(1))) state_d = StDrain;
      end
      StDrain: begin
        if (out_zero) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // arlen for the next AR is prepared one handshake ahead so it is a plain register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      arlen_q      <= '0;
      last_arlen_q <= '0;
    end else if (start_ok) begin
      addr_q       <= ctrl_offset;
      arlen_q      <= (bursts == C_LENGTH_WIDTH'(1)) ? last_arlen : LP_FULL_ARLEN;
      last_arlen_q <= last_arlen;
    end else if (ar_hs) begin
      addr_q  <= addr_q + LP_BURST_BYTES;
      arlen_q <= (rem_cnt == C_LENGTH_WIDTH'(2)) ? last_arlen_q : LP_FULL_ARLEN;
    end
  end

  cceip_kernel_example_updown_cnt #(
    .Width (LP_OUT_W)
  ) u_outstanding_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ({LP_OUT_W{1'b0}}),
    .incr     (ar_hs),
    .decr     (burst_done),
    .count    (out_cnt),
    .is_zero  (out_zero)
  );

  cceip_kernel_example_updown_cnt #(
    .Width (C_LENGTH_WIDTH)
  ) u_remaining_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .load_val (bursts),
    .incr     (1'b0),
    .decr     (ar_hs),
    .count    (rem_cnt),
    .is_zero  (rem_zero)
  );

endmodule

// File: tb/tb_cceip_kernel_example_rd_issuer.sv
// Bench for the read-address issuer: vector table, hand sequences and random commands vs a model.
module tb_cceip_kernel_example_rd_issuer;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_start;
  logic [63:0] ctrl_offset;
  logic [31:0] ctrl_length;
  logic        ctrl_busy;
  logic        ctrl_done;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic        burst_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cceip_kernel_example_rd_issuer #(
    .C_ADDR_WIDTH      (64),
    .C_DATA_WIDTH      (512),
    .C_LENGTH_WIDTH    (32),
    .C_BURST_LEN       (64),
    .C_MAX_OUTSTANDING (MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_start    (ctrl_start),
    .ctrl_offset   (ctrl_offset),
    .ctrl_length   (ctrl_length),
    .ctrl_busy     (ctrl_busy),
    .ctrl_done     (ctrl_done),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .burst_done    (burst_done)
  );

  typedef struct {
    logic [63:0] off;
    logic [31:0] len;
    int          n_ar;
    logic [7:0]  last_len;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_arvalid"}, m_axi_arvalid, 0);
    check({name, "_araddr"}, m_axi_araddr, 0);
    check({name, "_arlen"}, m_axi_arlen, 0);
    check({name, "_busy"}, ctrl_busy, 0);
    check({name, "_done"}, ctrl_done, 0);
  endtask

  // Drives one command with random ready/completion and checks every cycle against a
  // transaction model: burst list from byte arithmetic, outstanding count, done rule.
  task automatic run_cmd(input logic [63:0] off, input logic [31:0] len, input int rdy_pct,
                         input int bd_pct, output int n_ar, output logic [7:0] last_len);
    longint unsigned beats;
    int              n, issued, outs, cyc;
    bit              done_now, done_next, fin, exp_valid, rdy, bd, hs;
    logic [63:0]     e_addr;
    logic [7:0]      e_len;
    beats    = (longint'(len) + 63) / 64;
    n        = int'((beats + 63) / 64);
    n_ar     = 0;
    last_len = 0;
    issued   = 0;
    outs     = 0;
    done_now = 0;
    fin      = 0;
    @(negedge clk);
    ctrl_start    = 1'b1;
    ctrl_offset   = off;
    ctrl_length   = len;
    m_axi_arready = 1'b0;
    burst_done    = 1'b0;
    @(negedge clk);
    ctrl_start = 1'b0;
    cyc = 0;
    while (!fin && cyc < 4000) begin
      exp_valid = (issued < n) && (outs < MAX);
      check("arvalid", m_axi_arvalid, exp_valid);
      if (exp_valid) begin
        e_addr = off + 64'(issued) * 64'd4096;
        e_len  = (issued == n - 1) ? 8'((beats - 1) % 64) : 8'd63;
        check("araddr", m_axi_araddr, e_addr);
        check("arlen", m_axi_arlen, e_len);
      end
      check("done", ctrl_done, done_now);
      check("busy", ctrl_busy, !done_now);
      if (done_now) begin
        fin = 1;
      end else begin
        rdy = ($urandom_range(99) < rdy_pct);
        bd  = (outs > 0) ? ($urandom_range(99) < bd_pct) : ($urandom_range(99) < 2);
        m_axi_arready = rdy;
        burst_done    = bd;
        if (m_axi_arvalid && rdy) begin
          n_ar++;
          last_len = m_axi_arlen;
        end
        hs        = exp_valid && rdy;
        done_next = (issued == n) && (outs == 0);
        if (hs) issued++;
        if (hs && !bd) outs++;
        else if (bd && !hs && outs > 0) outs--;
        done_now = done_next;
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) check("cmd_timeout", 1, 0);
    m_axi_arready = 1'b0;
    burst_done    = 1'b0;
    @(negedge clk);
    check("done_one_cycle", ctrl_done, 0);
    check("busy_after_done", ctrl_busy, 0);
  endtask

  initial begin
    int          n_ar;
    logic [7:0]  last_len;
    logic [63:0] roff;
    logic [31:0] rlen;

    tbl[0] = '{64'h1000, 32'd8192, 2, 8'd63};
    tbl[1] = '{64'h0, 32'd4160, 2, 8'd0};
    tbl[2] = '{64'h40000, 32'd100, 1, 8'd1};
    tbl[3] = '{64'h0, 32'd0, 0, 8'd0};
    tbl[4] = '{64'h8000, 32'd4096, 1, 8'd63};
    tbl[5] = '{64'h0, 32'd1, 1, 8'd0};
    tbl[6] = '{64'h10000, 32'd40960, 10, 8'd63};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_F000, 32'd8192, 2, 8'd63};
    tbl[8] = '{64'h0, 32'd4097, 2, 8'd0};
    tbl[9] = '{64'h2000, 32'd262208, 65, 8'd0};

    rst           = 1'b1;
    ctrl_start    = 1'b0;
    ctrl_offset   = '0;
    ctrl_length   = '0;
    m_axi_arready = 1'b0;
    burst_done    = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_cmd(tbl[i].off, tbl[i].len, 100, 100, n_ar, last_len);
      check($sformatf("tbl%0d_n_ar", i), 64'(n_ar), 64'(tbl[i].n_ar));
      check($sformatf("tbl%0d_last_arlen", i), last_len, tbl[i].last_len);
    end

    // AR stall with an ignored start pulse in the middle.
    @(negedge clk);
    ctrl_start = 1'b1; ctrl_offset = 64'h3000; ctrl_length = 32'd8192; m_axi_arready = 1'b0;
    @(negedge clk);
    ctrl_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_arvalid", m_axi_arvalid, 1);
      check("stall_araddr", m_axi_araddr, 64'h3000);
      check("stall_arlen", m_axi_arlen, 63);
      ctrl_start = (i == 2);
      if (i == 2) begin
        ctrl_offset = 64'h9000;
        ctrl_length = 32'd4096;
      end
      @(negedge clk);
    end
    ctrl_start    = 1'b0;
    m_axi_arready = 1'b1;
    check("stall_release_addr", m_axi_araddr, 64'h3000);
    @(negedge clk);
    check("stall_second_arvalid", m_axi_arvalid, 1);
    check("stall_second_addr", m_axi_araddr, 64'h4000);
    @(negedge clk);
    m_axi_arready = 1'b0;
    check("stall_drain_arvalid", m_axi_arvalid, 0);
    check("stall_drain_busy", ctrl_busy, 1);
    burst_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    burst_done = 1'b0;
    check("stall_drain_wait", ctrl_done, 0);
    @(negedge clk);
    check("stall_done", ctrl_done, 1);
    check("stall_busy_low", ctrl_busy, 0);
    @(negedge clk);
    check("stall_no_restart", m_axi_arvalid, 0);

    // Credit limit: 10 bursts, completions withheld.
    @(negedge clk);
    ctrl_start = 1'b1; ctrl_offset = 64'h0; ctrl_length = 32'd40960; m_axi_arready = 1'b1;
    @(negedge clk);
    ctrl_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("credit_arvalid", m_axi_arvalid, 1);
      check("credit_araddr", m_axi_araddr, 64'(i) * 64'h1000);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      check("credit_blocked", m_axi_arvalid, 0);
      @(negedge clk);
    end
    burst_done = 1'b1;
    @(negedge clk);
    check("credit_fifth_arvalid", m_axi_arvalid, 1);
    check("credit_fifth_addr", m_axi_araddr, 64'h4000);
    @(negedge clk);
    burst_done = 1'b0;
    check("credit_coincide_arvalid", m_axi_arvalid, 1);
    check("credit_sixth_addr", m_axi_araddr, 64'h5000);
    @(negedge clk);
    check("credit_full_again", m_axi_arvalid, 0);

    // Asynchronous reset in the middle of ISSUE.
    #2;
    rst = 1'b1;
    m_axi_arready = 1'b0;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_cmd(64'h0, 32'd4096, 100, 100, n_ar, last_len);
    check("post_rst_n_ar", 64'(n_ar), 1);
    check("post_rst_arlen", last_len, 63);

    for (int k = 0; k < 25; k++) begin
      roff = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_F000;
      rlen = (k % 5 == 0) ? 32'($urandom_range(200)) : 32'($urandom_range(80000));
      run_cmd(roff, rlen, int'($urandom_range(40, 100)), int'($urandom_range(10, 60)),
              n_ar, last_len);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
